// File: rtl/processor_pkg.sv
// Shared types and helpers for the multicore row scheduler: FSM states,
// default load-phase marker addresses and batch sizing functions.
package processor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_SYNC      = 3'd2,
        ST_LOAD      = 3'd3,
        ST_RUN       = 3'd4,
        ST_BATCH_RST = 3'd5,
        ST_DONE      = 3'd6
    } sched_state_t;

    localparam logic [7:0] DEF_LOAD_BEGIN_ADDR = 8'd5;
    localparam logic [7:0] DEF_LOAD_END_ADDR   = 8'd23;

    // Size of the next batch: never more rows than are left, never more than the core count.
    function automatic logic [31:0] min_rows(input logic [31:0] rows_left, input logic [31:0] cores);
        return (rows_left < cores) ? rows_left : cores;
    endfunction

    // Mask with the low n bits set, saturating at the 16-core maximum.
    function automatic logic [15:0] low_mask(input logic [31:0] n);
        logic [31:0] full_v;
        full_v = (32'd1 << n) - 32'd1;
        return (n >= 32'd16) ? 16'hFFFF : full_v[15:0];
    endfunction

endpackage

// File: rtl/core_bus_merge.sv
// Merges the RAM strobes of the active cores onto the shared RAM port and
// flags cycles where more than one active core drives a write.
module core_bus_merge #(
    parameter int NO_OF_CORES = 4
) (
    input  logic [NO_OF_CORES-1:0] core_read,
    input  logic [NO_OF_CORES-1:0] core_write,
    input  logic [NO_OF_CORES-1:0] active_mask,
    output logic                   ram_read,
    output logic                   ram_write,
    output logic                   bus_conflict
);

    logic [NO_OF_CORES-1:0] read_s;
    logic [NO_OF_CORES-1:0] write_s;
    logic [4:0]             wr_cnt_s;

    assign read_s  = core_read  & active_mask;
    assign write_s = core_write & active_mask;

    // Population count of active writers.
    always_comb begin
        wr_cnt_s = 5'd0;
        for (int i = 0; i < NO_OF_CORES; i++) begin
            wr_cnt_s = wr_cnt_s + {4'd0, write_s[i]};
        end
    end

    assign ram_read     = |read_s;
    assign ram_write    = |write_s;
    assign bus_conflict = (wr_cnt_s > 5'd1);

endmodule

// File: rtl/multicore_row_scheduler.sv
// Batches work rows over NO_OF_CORES cores: launches a batch, hands the RAM to
// one core at a time for loading, runs the batch together, then resets it.
module multicore_row_scheduler
    import processor_pkg::*;
#(
    parameter int                     NO_OF_CORES     = 4,
    parameter int                     ROW_W           = 8,
    parameter int                     ADDRESS_LEN     = 8,
    parameter logic [ADDRESS_LEN-1:0] LOAD_BEGIN_ADDR = ADDRESS_LEN'(DEF_LOAD_BEGIN_ADDR),
    parameter logic [ADDRESS_LEN-1:0] LOAD_END_ADDR   = ADDRESS_LEN'(DEF_LOAD_END_ADDR),
    parameter int                     TIMEOUT_CYCLES  = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [ROW_W-1:0]                   num_rows,
    input  logic [ADDRESS_LEN*NO_OF_CORES-1:0] core_addr,
    input  logic [NO_OF_CORES-1:0]             core_finish,
    input  logic [NO_OF_CORES-1:0]             core_read,
    input  logic [NO_OF_CORES-1:0]             core_write,
    output logic [NO_OF_CORES-1:0]             core_start,
    output logic [NO_OF_CORES-1:0]             core_reset,
    output logic                               ram_read,
    output logic                               ram_write,
    output logic [NO_OF_CORES-1:0]             active_mask,
    output logic                               busy,
    output logic                               finish_process,
    output logic                               timeout_err,
    output logic                               bus_conflict
);

    localparam int          IDX_W    = (NO_OF_CORES > 1) ? $clog2(NO_OF_CORES) : 1;
    localparam bit          WD_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] WD_LIMIT = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    sched_state_t           state_r,       state_s;
    logic [ROW_W-1:0]       rows_left_r,   rows_left_s;
    logic [4:0]             batch_n_r,     batch_n_s;
    logic [IDX_W-1:0]       load_idx_r,    load_idx_s;
    logic [31:0]            wd_r,          wd_s;
    logic [NO_OF_CORES-1:0] core_start_r,  core_start_s;
    logic [NO_OF_CORES-1:0] core_reset_r,  core_reset_s;
    logic [NO_OF_CORES-1:0] active_mask_r, active_mask_s;
    logic                   busy_r,        busy_s;
    logic                   finish_r,      finish_s;
    logic                   timeout_r,     timeout_s;

    logic [ADDRESS_LEN-1:0] addr_s [NO_OF_CORES];
    logic [NO_OF_CORES-1:0] begin_hit_s;
    logic                   all_ready_s;
    logic                   load_done_s;
    logic                   last_load_s;
    logic                   all_finish_s;
    logic                   counting_s;
    logic                   wd_fire_s;
    logic [4:0]             next_n_s;
    logic [15:0]            mask16_s;
    logic [NO_OF_CORES-1:0] next_mask_s;
    logic [NO_OF_CORES-1:0] onehot_next_s;

    for (genvar g = 0; g < NO_OF_CORES; g++) begin : g_addr
        assign addr_s[g]      = core_addr[ADDRESS_LEN*g +: ADDRESS_LEN];
        assign begin_hit_s[g] = (addr_s[g] == LOAD_BEGIN_ADDR);
    end

    // Cores outside the batch are forced to "ready" so they cannot hold SYNC.
    assign all_ready_s   = &(begin_hit_s | ~active_mask_r);
    assign load_done_s   = (addr_s[load_idx_r] == LOAD_END_ADDR);
    assign last_load_s   = ({{(5-IDX_W){1'b0}}, load_idx_r} == (batch_n_r - 5'd1));
    assign all_finish_s  = ((core_finish & active_mask_r) == active_mask_r);
    assign next_n_s      = 5'(min_rows(32'(rows_left_r), 32'(NO_OF_CORES)));
    assign mask16_s      = low_mask({27'd0, next_n_s});
    assign next_mask_s   = mask16_s[NO_OF_CORES-1:0];
    assign onehot_next_s = NO_OF_CORES'(1) << (load_idx_r + IDX_W'(1));
    assign counting_s    = (state_r == ST_SYNC) || (state_r == ST_LOAD) || (state_r == ST_RUN);
    assign wd_fire_s     = WD_EN && counting_s && (wd_r == WD_LIMIT);

    // Next-state and next-output logic of the batch scheduler.
    always_comb begin
        state_s       = state_r;
        rows_left_s   = rows_left_r;
        batch_n_s     = batch_n_r;
        load_idx_s    = load_idx_r;
        core_start_s  = core_start_r;
        core_reset_s  = '0;
        active_mask_s = active_mask_r;
        finish_s      = finish_r;
        timeout_s     = timeout_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    rows_left_s = num_rows;
                    finish_s    = 1'b0;
                    timeout_s   = 1'b0;
                    if (num_rows == '0) begin
                        state_s  = ST_DONE;
                        finish_s = 1'b1;
                    end else begin
                        state_s = ST_LAUNCH;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_LAUNCH: begin
                batch_n_s     = next_n_s;
                active_mask_s = next_mask_s;
                core_start_s  = next_mask_s;
                rows_left_s   = rows_left_r - ROW_W'(next_n_s);
                state_s       = ST_SYNC;
            end
            ST_SYNC: begin
                if (all_ready_s) begin
                    core_start_s = NO_OF_CORES'(1);
                    load_idx_s   = '0;
                    state_s      = ST_LOAD;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_LOAD: begin
                if (load_done_s && last_load_s) begin
                    core_start_s = active_mask_r;
                    state_s      = ST_RUN;
                end else if (load_done_s) begin
                    core_start_s = onehot_next_s;
                    load_idx_s   = load_idx_r + IDX_W'(1);
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (all_finish_s && (rows_left_r == '0)) begin
                    core_start_s  = '0;
                    active_mask_s = '0;
                    finish_s      = 1'b1;
                    state_s       = ST_DONE;
                end else if (all_finish_s) begin
                    core_reset_s = next_mask_s;
                    core_start_s = '0;
                    state_s      = ST_BATCH_RST;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_BATCH_RST: begin
                state_s = ST_LAUNCH;
            end
            default: begin
                state_s       = ST_IDLE;
                core_start_s  = '0;
                active_mask_s = '0;
            end
        endcase

        // An expired watchdog abandons the job regardless of phase progress.
        if (wd_fire_s) begin
            timeout_s     = 1'b1;
            finish_s      = 1'b0;
            core_start_s  = '0;
            core_reset_s  = '0;
            active_mask_s = '0;
            state_s       = ST_DONE;
        end else begin
            timeout_s = timeout_s;
        end
    end

    // Watchdog count and busy flag follow the chosen next state.
    always_comb begin
        busy_s = (state_s != ST_IDLE) && (state_s != ST_DONE);
        if (state_s != state_r) begin
            wd_s = 32'd0;
        end else if (WD_EN && counting_s) begin
            wd_s = wd_r + 32'd1;
        end else begin
            wd_s = 32'd0;
        end
    end

    // State and registered outputs; reset dominates every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            rows_left_r   <= '0;
            batch_n_r     <= 5'd0;
            load_idx_r    <= '0;
            wd_r          <= 32'd0;
            core_start_r  <= '0;
            core_reset_r  <= '0;
            active_mask_r <= '0;
            busy_r        <= 1'b0;
            finish_r      <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            rows_left_r   <= rows_left_s;
            batch_n_r     <= batch_n_s;
            load_idx_r    <= load_idx_s;
            wd_r          <= wd_s;
            core_start_r  <= core_start_s;
            core_reset_r  <= core_reset_s;
            active_mask_r <= active_mask_s;
            busy_r        <= busy_s;
            finish_r      <= finish_s;
            timeout_r     <= timeout_s;
        end
    end

    assign core_start     = core_start_r;
    assign core_reset     = core_reset_r;
    assign active_mask    = active_mask_r;
    assign busy           = busy_r;
    assign finish_process = finish_r;
    assign timeout_err    = timeout_r;

    core_bus_merge #(
        .NO_OF_CORES (NO_OF_CORES)
    ) u_merge (
        .core_read    (core_read),
        .core_write   (core_write),
        .active_mask  (active_mask_r),
        .ram_read     (ram_read),
        .ram_write    (ram_write),
        .bus_conflict (bus_conflict)
    );

endmodule

// File: tb/tb_multicore_row_scheduler.sv
// Directed bench for multicore_row_scheduler with a small behavioural core
// model (ready at addr 5, loaded at addr 23 after 10 owned cycles, finish after 20).
module tb_multicore_row_scheduler;

    localparam int NC = 4;
    localparam int AL = 8;
    localparam int RW = 8;
    localparam int TO = 50;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [RW-1:0]   num_rows;
    logic [AL*NC-1:0] core_addr;
    logic [NC-1:0]   core_finish;
    logic [NC-1:0]   core_read;
    logic [NC-1:0]   core_write;
    logic [NC-1:0]   core_start;
    logic [NC-1:0]   core_reset;
    logic            ram_read;
    logic            ram_write;
    logic [NC-1:0]   active_mask;
    logic            busy;
    logic            finish_process;
    logic            timeout_err;
    logic            bus_conflict;

    int n_cmp = 0;
    int n_err = 0;

    int            ph  [NC];
    int            cnt [NC];
    logic [NC-1:0] stall_mask = '0;

    always #5 clk = ~clk;

    multicore_row_scheduler #(
        .NO_OF_CORES    (NC),
        .ROW_W          (RW),
        .ADDRESS_LEN    (AL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_rows       (num_rows),
        .core_addr      (core_addr),
        .core_finish    (core_finish),
        .core_read      (core_read),
        .core_write     (core_write),
        .core_start     (core_start),
        .core_reset     (core_reset),
        .ram_read       (ram_read),
        .ram_write      (ram_write),
        .active_mask    (active_mask),
        .busy           (busy),
        .finish_process (finish_process),
        .timeout_err    (timeout_err),
        .bus_conflict   (bus_conflict)
    );

    task automatic drive_model();
        for (int c = 0; c < NC; c++) begin
            core_addr[c*AL +: AL] = (ph[c] == 0) ? 8'd0 : (ph[c] == 1) ? 8'd5 : 8'd23;
            core_finish[c]        = (ph[c] == 3);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            ph[c]  = 0;
            cnt[c] = 0;
        end
        drive_model();
    endtask

    // Advance to the next falling edge and step the core model from DUT outputs.
    task automatic tick();
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            if (core_reset[c]) begin
                ph[c]  = 0;
                cnt[c] = 0;
            end else begin
                case (ph[c])
                    0: if (core_start[c]) begin ph[c] = 1; cnt[c] = 0; end
                    1: if (core_start == (NC'(1) << c)) begin
                           cnt[c]++;
                           if (cnt[c] >= 10 && !stall_mask[c]) begin ph[c] = 2; cnt[c] = 0; end
                       end
                    2: if (core_start[c]) begin
                           cnt[c]++;
                           if (cnt[c] >= 20) ph[c] = 3;
                       end
                    default: ;
                endcase
            end
        end
        drive_model();
    endtask

    task automatic pulse_start(input logic [RW-1:0] n);
        start    = 1'b1;
        num_rows = n;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_rows = '0;
        core_read = '0; core_write = '0;
        model_clear();
        repeat (3) tick();
        n_cmp++;
        if ({core_start, core_reset, active_mask} !== 12'd0) begin
            n_err++; $display("FAIL reset_vectors: got %b required 0", {core_start, core_reset, active_mask});
        end
        n_cmp++;
        if ({busy, finish_process, timeout_err, ram_read, ram_write, bus_conflict} !== 6'd0) begin
            n_err++; $display("FAIL reset_flags: got %b required 000000",
                              {busy, finish_process, timeout_err, ram_read, ram_write, bus_conflict});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero_rows();
        logic any_start = 1'b0;
        logic fin_drop  = 1'b0;
        pulse_start(8'd0);
        n_cmp++;
        if (finish_process !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL zero_rows_finish: finish=%b busy=%b required 1 0", finish_process, busy);
        end
        for (int i = 0; i < 6; i++) begin
            if (core_start !== 4'd0) any_start = 1'b1;
            if (finish_process !== 1'b1) fin_drop = 1'b1;
            tick();
        end
        n_cmp++;
        if (any_start !== 1'b0 || fin_drop !== 1'b0) begin
            n_err++; $display("FAIL zero_rows_hold: core_start_seen=%b finish_dropped=%b required 0 0", any_start, fin_drop);
        end
    endtask

    task automatic test_six_rows();
        logic [3:0] exp_cs [12] = '{4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111,
                                    4'b0000, 4'b0011, 4'b0001, 4'b0010, 4'b0011, 4'b0000};
        logic [3:0] exp_am [3]  = '{4'b1111, 4'b0011, 4'b0000};
        logic [3:0] cs_q [$];
        logic [3:0] am_q [$];
        logic [3:0] prev_cs, prev_am, rst_val;
        int         rst_cycles = 0;
        int         guard = 0;
        model_clear();
        pulse_start(8'd6);
        n_cmp++;
        if (busy !== 1'b1 || finish_process !== 1'b0) begin
            n_err++; $display("FAIL six_accept: busy=%b finish=%b required 1 0", busy, finish_process);
        end
        prev_cs = core_start; prev_am = active_mask; rst_val = '0;
        while (!finish_process && guard < 2000) begin
            tick(); guard++;
            if (core_start !== prev_cs) begin cs_q.push_back(core_start); prev_cs = core_start; end
            if (active_mask !== prev_am) begin am_q.push_back(active_mask); prev_am = active_mask; end
            if (core_reset !== 4'd0) begin rst_cycles++; rst_val = core_reset; end
        end
        n_cmp++;
        if (guard >= 2000) begin n_err++; $display("FAIL six_timeout: no finish after %0d cycles", guard); end
        n_cmp++;
        if (cs_q.size() != 12) begin
            n_err++; $display("FAIL six_start_len: got %0d changes required 12", cs_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_cmp++;
                if (cs_q[i] !== exp_cs[i]) begin
                    n_err++; $display("FAIL six_start_seq[%0d]: got %b required %b", i, cs_q[i], exp_cs[i]);
                end
            end
        end
        n_cmp++;
        if (am_q.size() != 3 || am_q[0] !== exp_am[0] || am_q[1] !== exp_am[1] || am_q[2] !== exp_am[2]) begin
            n_err++; $display("FAIL six_mask_seq: got %0d changes first %b required 1111,0011,0000", am_q.size(),
                              (am_q.size() > 0) ? am_q[0] : 4'bx);
        end
        n_cmp++;
        if (rst_cycles != 1 || rst_val !== 4'b0011) begin
            n_err++; $display("FAIL six_core_reset: got %0d cycles value %b required 1 cycle 0011", rst_cycles, rst_val);
        end
        n_cmp++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || core_start !== 4'd0) begin
            n_err++; $display("FAIL six_done: busy=%b timeout=%b core_start=%b required 0 0 0000", busy, timeout_err, core_start);
        end
    endtask

    task automatic test_merge_and_busy_start();
        logic seen_load2 = 1'b0;
        logic bad_mask   = 1'b0;
        int   guard = 0;
        model_clear();
        pulse_start(8'd3);
        while (!(seen_load2 && core_start === 4'b0111) && guard < 500) begin
            tick(); guard++;
            if (core_start === 4'b0100) seen_load2 = 1'b1;
        end
        n_cmp++;
        if (guard >= 500) begin n_err++; $display("FAIL merge_reach_run: not in RUN after %0d cycles", guard); end
        core_write = 4'b0101; #1;
        n_cmp++;
        if (ram_write !== 1'b1 || bus_conflict !== 1'b1) begin
            n_err++; $display("FAIL merge_w0101: ram_write=%b conflict=%b required 1 1", ram_write, bus_conflict);
        end
        core_write = 4'b1000; #1;
        n_cmp++;
        if (ram_write !== 1'b0 || bus_conflict !== 1'b0) begin
            n_err++; $display("FAIL merge_w1000: ram_write=%b conflict=%b required 0 0", ram_write, bus_conflict);
        end
        core_write = 4'b0010; core_read = 4'b1000; #1;
        n_cmp++;
        if (ram_write !== 1'b1 || bus_conflict !== 1'b0 || ram_read !== 1'b0) begin
            n_err++; $display("FAIL merge_w0010_r1000: ram_write=%b conflict=%b ram_read=%b required 1 0 0",
                              ram_write, bus_conflict, ram_read);
        end
        core_write = 4'b0000; core_read = 4'b0100; #1;
        n_cmp++;
        if (ram_read !== 1'b1 || ram_write !== 1'b0) begin
            n_err++; $display("FAIL merge_r0100: ram_read=%b ram_write=%b required 1 0", ram_read, ram_write);
        end
        core_read = 4'b0000;
        pulse_start(8'd9);
        guard = 0;
        while (!finish_process && guard < 500) begin
            tick(); guard++;
            if (active_mask !== 4'b0111 && active_mask !== 4'b0000) bad_mask = 1'b1;
        end
        n_cmp++;
        if (guard >= 500 || bad_mask !== 1'b0) begin
            n_err++; $display("FAIL busy_start_ignored: cycles=%0d bad_mask=%b required finish and no new batch", guard, bad_mask);
        end
    endtask

    task automatic test_single_row();
        logic [3:0] cs_q [$];
        logic [3:0] prev_cs;
        logic       any_rst = 1'b0;
        logic       checked = 1'b0;
        int         guard = 0;
        model_clear();
        pulse_start(8'd1);
        prev_cs = core_start;
        while (!finish_process && guard < 500) begin
            tick(); guard++;
            if (core_start !== prev_cs) begin cs_q.push_back(core_start); prev_cs = core_start; end
            if (core_reset !== 4'd0) any_rst = 1'b1;
            if (!checked && ph[0] == 2) begin
                checked = 1'b1;
                tick(); guard++;
                n_cmp++;
                if (core_start !== 4'b0001 || active_mask !== 4'b0001 || busy !== 1'b1) begin
                    n_err++; $display("FAIL single_run: core_start=%b mask=%b busy=%b required 0001 0001 1",
                                      core_start, active_mask, busy);
                end
            end
        end
        n_cmp++;
        if (guard >= 500 || checked !== 1'b1 || timeout_err !== 1'b0) begin
            n_err++; $display("FAIL single_finish: cycles=%0d loaded=%b timeout=%b required finish loaded=1 timeout=0",
                              guard, checked, timeout_err);
        end
        n_cmp++;
        if (cs_q.size() != 2 || cs_q[0] !== 4'b0001 || cs_q[1] !== 4'b0000 || any_rst !== 1'b0) begin
            n_err++; $display("FAIL single_start_seq: changes=%0d core_reset_seen=%b required 0001,0000 and no reset",
                              cs_q.size(), any_rst);
        end
    endtask

    task automatic test_reset_mid_load();
        int guard = 0;
        model_clear();
        pulse_start(8'd4);
        while (core_start !== 4'b0100 && guard < 500) begin tick(); guard++; end
        n_cmp++;
        if (guard >= 500) begin n_err++; $display("FAIL midreset_reach: load_idx 2 not seen after %0d cycles", guard); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({core_start, core_reset, active_mask} !== 12'd0 ||
            {busy, finish_process, timeout_err, ram_read, ram_write, bus_conflict} !== 6'd0) begin
            n_err++; $display("FAIL midreset_clear: vec=%b flags=%b required all 0", {core_start, core_reset, active_mask},
                              {busy, finish_process, timeout_err, ram_read, ram_write, bus_conflict});
        end
        model_clear();
        pulse_start(8'd1);
        n_cmp++;
        if (busy !== 1'b1 || core_start !== 4'd0 || active_mask !== 4'd0) begin
            n_err++; $display("FAIL restart_launch: busy=%b core_start=%b mask=%b required 1 0000 0000", busy, core_start, active_mask);
        end
        tick();
        n_cmp++;
        if (core_start !== 4'b0001 || active_mask !== 4'b0001) begin
            n_err++; $display("FAIL restart_sync: core_start=%b mask=%b required 0001 0001", core_start, active_mask);
        end
        guard = 0;
        while (!finish_process && guard < 500) begin tick(); guard++; end
        n_cmp++;
        if (guard >= 500) begin n_err++; $display("FAIL restart_finish: no finish after %0d cycles", guard); end
    endtask

    task automatic test_timeout();
        int guard = 0;
        int k = 0;
        model_clear();
        stall_mask = 4'b0010;
        pulse_start(8'd2);
        while (core_start !== 4'b0001 && guard < 100) begin tick(); guard++; end
        n_cmp++;
        if (guard >= 100) begin n_err++; $display("FAIL wd_reach_load: LOAD not seen after %0d cycles", guard); end
        while (!timeout_err && k < 80) begin tick(); k++; end
        n_cmp++;
        if (k != 50) begin n_err++; $display("FAIL wd_latency: timeout after %0d cycles required 50", k); end
        n_cmp++;
        if (finish_process !== 1'b0 || core_start !== 4'd0 || active_mask !== 4'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL wd_outputs: finish=%b core_start=%b mask=%b busy=%b required 0 0000 0000 0",
                              finish_process, core_start, active_mask, busy);
        end
        stall_mask = '0;
        tick();
        n_cmp++;
        if (timeout_err !== 1'b1) begin n_err++; $display("FAIL wd_hold: timeout_err=%b required 1", timeout_err); end
        pulse_start(8'd0);
        n_cmp++;
        if (timeout_err !== 1'b0 || finish_process !== 1'b1) begin
            n_err++; $display("FAIL wd_clear_on_start: timeout=%b finish=%b required 0 1", timeout_err, finish_process);
        end
    endtask

    initial begin
        test_reset();
        test_zero_rows();
        test_six_rows();
        test_merge_and_busy_start();
        test_single_row();
        test_reset_mid_load();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
